branch_trace_mon: RTL and testbench

Hardware performance and trace monitor for core control-flow events. It sits directly downstream of the core's jump/branch control signals (`jump_req`, `jump_addr`, `pc_if`, `branch_ex`, `branch_cal`, `branch_res`). It counts rising edges of each event and captures a `{pc_if, jump_addr}` record for every new jump request into a small trace FIFO. Counters are readable through a registered select/read port, and the FIFO drains through a valid/ready interface, so the SoC can gather the jump and branch statistics in silicon.

---
 rtl/branch_trace_mon_pkg.sv | 24 ++
 rtl/trace_sync_fifo.sv | 55 +++++
 rtl/branch_trace_mon.sv | 130 +++++++++++++
 tb/tb_branch_trace_mon.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_trace_mon_pkg.sv
// Shared constants and types for the branch/jump trace monitor.
// Read-select codes, the trace record layout and the status word packing live here.
package branch_trace_mon_pkg;

   localparam logic [2:0] RD_SEL_JUMP   = 3'd0;
   localparam logic [2:0] RD_SEL_BEX    = 3'd1;
   localparam logic [2:0] RD_SEL_BCAL   = 3'd2;
   localparam logic [2:0] RD_SEL_BRES   = 3'd3;
   localparam logic [2:0] RD_SEL_DROP   = 3'd4;
   localparam logic [2:0] RD_SEL_STATUS = 3'd5;

   localparam int TRACE_W = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
   } trace_rec_t;

   // Status word: overflow flag above a 5-bit occupancy field.
   function automatic logic [31:0] status_word(input logic ovf, input logic [4:0] level);
      return {26'b0, ovf, level};
   endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, flush, level output and unreset storage.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module trace_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // Flush wins over both ports; a pop on an empty FIFO is ignored.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_trace_mon.sv
// Control-flow event monitor: rising-edge counters for jump/branch events, a readable
// counter bank, and a trace FIFO of {pc_if, jump_addr} records for each new jump request.
module branch_trace_mon
   import branch_trace_mon_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int TRACE_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        jump_req_i,
   input  logic [31:0] jump_addr_i,
   input  logic [31:0] pc_if_i,
   input  logic        branch_ex_i,
   input  logic        branch_cal_i,
   input  logic        branch_res_i,
   input  logic [2:0]  rd_sel_i,
   output logic [31:0] rd_data_o,
   output logic        trace_valid_o,
   input  logic        trace_ready_i,
   output logic [31:0] trace_pc_o,
   output logic [31:0] trace_addr_o,
   output logic        trace_ovf_o
);

   localparam int LW = $clog2(TRACE_DEPTH) + 1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
      return v;
   endfunction

   logic             jump_req_p1, branch_ex_p1, branch_cal_p1, branch_res_p1;
   logic             jump_pedge, bex_pedge, bcal_pedge, bres_pedge;
   logic [CNT_W-1:0] jump_cnt, bex_cnt, bcal_cnt, bres_cnt, drop_cnt;
   logic             fifo_full, fifo_empty, pop, push_try, drop;
   logic [LW-1:0]    fifo_level;
   logic [4:0]       level5;
   logic [31:0]      rd_next;
   trace_rec_t       rec_in, rec_out;

   // Stage p1: one-cycle delayed copies of the event levels, free-running regardless of en_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         jump_req_p1   <= 1'b0;
         branch_ex_p1  <= 1'b0;
         branch_cal_p1 <= 1'b0;
         branch_res_p1 <= 1'b0;
      end else begin
         jump_req_p1   <= jump_req_i;
         branch_ex_p1  <= branch_ex_i;
         branch_cal_p1 <= branch_cal_i;
         branch_res_p1 <= branch_res_i;
      end
   end

   assign jump_pedge = jump_req_i   & ~jump_req_p1;
   assign bex_pedge  = branch_ex_i  & ~branch_ex_p1;
   assign bcal_pedge = branch_cal_i & ~branch_cal_p1;
   assign bres_pedge = branch_res_i & ~branch_res_p1;

   assign pop      = trace_valid_o & trace_ready_i;
   assign push_try = en_i & jump_pedge & ~clr_i;
   // A full FIFO still takes the record when the head leaves in the same cycle.
   assign drop     = push_try & fifo_full & ~pop;

   assign rec_in = '{pc: pc_if_i, addr: jump_addr_i};

   trace_sync_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (TRACE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr_i),
      .push  (push_try),
      .pop   (pop),
      .wdata (rec_in),
      .rdata (rec_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign trace_valid_o = ~fifo_empty;
   assign trace_pc_o    = rec_out.pc;
   assign trace_addr_o  = rec_out.addr;
   assign level5        = 5'(fifo_level);

   // Stage p1: event counters and sticky overflow; clear beats any same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         jump_cnt    <= '0;
         bex_cnt     <= '0;
         bcal_cnt    <= '0;
         bres_cnt    <= '0;
         drop_cnt    <= '0;
         trace_ovf_o <= 1'b0;
      end else begin
         jump_cnt <= sat_inc(jump_cnt, en_i & jump_pedge);
         bex_cnt  <= sat_inc(bex_cnt,  en_i & bex_pedge);
         bcal_cnt <= sat_inc(bcal_cnt, en_i & bcal_pedge);
         bres_cnt <= sat_inc(bres_cnt, en_i & bres_pedge);
         drop_cnt <= sat_inc(drop_cnt, drop);
         if (drop) trace_ovf_o <= 1'b1;
      end
   end

   always_comb begin
      rd_next = '0;
      case (rd_sel_i)
         RD_SEL_JUMP:   rd_next = 32'(jump_cnt);
         RD_SEL_BEX:    rd_next = 32'(bex_cnt);
         RD_SEL_BCAL:   rd_next = 32'(bcal_cnt);
         RD_SEL_BRES:   rd_next = 32'(bres_cnt);
         RD_SEL_DROP:   rd_next = 32'(drop_cnt);
         RD_SEL_STATUS: rd_next = status_word(trace_ovf_o, level5);
         default:       rd_next = '0;
      endcase
   end

   // Stage p2: registered read port.
   always_ff @(posedge clk) begin
      if (rst) rd_data_o <= '0;
      else     rd_data_o <= rd_next;
   end

endmodule

// File: tb/tb_branch_trace_mon.sv
// Directed plus randomized bench for branch_trace_mon, checked against a queue-based model.
// Two instances (32-bit and 4-bit counters) share stimulus to exercise saturation.
module tb_branch_trace_mon;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst, en, clr, jreq, bex, bcal, bres, ready;
   logic [31:0] jaddr, pc;
   logic [2:0]  sel;

   logic [31:0] rd32, pc32, addr32, rd4, pc4, addr4;
   logic        valid32, ovf32, valid4, ovf4;

   branch_trace_mon #(.CNT_W(32), .TRACE_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .jump_req_i(jreq), .jump_addr_i(jaddr),
      .pc_if_i(pc), .branch_ex_i(bex), .branch_cal_i(bcal), .branch_res_i(bres),
      .rd_sel_i(sel), .rd_data_o(rd32), .trace_valid_o(valid32), .trace_ready_i(ready),
      .trace_pc_o(pc32), .trace_addr_o(addr32), .trace_ovf_o(ovf32));

   branch_trace_mon #(.CNT_W(4), .TRACE_DEPTH(D)) dut4 (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .jump_req_i(jreq), .jump_addr_i(jaddr),
      .pc_if_i(pc), .branch_ex_i(bex), .branch_cal_i(bcal), .branch_res_i(bres),
      .rd_sel_i(sel), .rd_data_o(rd4), .trace_valid_o(valid4), .trace_ready_i(ready),
      .trace_pc_o(pc4), .trace_addr_o(addr4), .trace_ovf_o(ovf4));

   always #5 clk = ~clk;

   // Reference model: counters indexed jump, bex, bcal, bres, drop.
   logic [63:0]     q[$];
   longint unsigned c32[5];
   longint unsigned c4[5];
   bit              m_ovf;
   logic [31:0]     e_rd32, e_rd4;
   bit              p_j, p_x, p_c, p_r;
   int              checks = 0;
   int              failures = 0;

   function automatic longint unsigned bump(longint unsigned v, longint unsigned mx, bit inc);
      return (inc && v < mx) ? v + 1 : v;
   endfunction

   function logic [31:0] pick(bit narrow, logic [2:0] s);
      int i;
      i = int'(s);
      if (i <= 4) return narrow ? 32'(c4[i]) : 32'(c32[i]);
      if (i == 5) return (m_ovf ? 32'h20 : 32'h0) + 32'(q.size());
      return 32'h0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 5; i++) begin
         c32[i] = 0;
         c4[i]  = 0;
      end
      q.delete();
      m_ovf = 0;
   endtask

   task automatic model_step();
      bit je, xe, ce, re, pp, dr;
      if (rst) begin
         clear_model();
         e_rd32 = 0; e_rd4 = 0;
         p_j = 0; p_x = 0; p_c = 0; p_r = 0;
         return;
      end
      e_rd32 = pick(1'b0, sel);
      e_rd4  = pick(1'b1, sel);
      je = jreq && !p_j; xe = bex && !p_x; ce = bcal && !p_c; re = bres && !p_r;
      pp = (q.size() != 0) && ready;
      if (clr) clear_model();
      else begin
         if (pp) void'(q.pop_front());
         dr = 0;
         if (en && je) begin
            if (q.size() < D) q.push_back({pc, jaddr});
            else begin dr = 1; m_ovf = 1; end
         end
         c32[0] = bump(c32[0], 64'hFFFF_FFFF, en && je);  c4[0] = bump(c4[0], 15, en && je);
         c32[1] = bump(c32[1], 64'hFFFF_FFFF, en && xe);  c4[1] = bump(c4[1], 15, en && xe);
         c32[2] = bump(c32[2], 64'hFFFF_FFFF, en && ce);  c4[2] = bump(c4[2], 15, en && ce);
         c32[3] = bump(c32[3], 64'hFFFF_FFFF, en && re);  c4[3] = bump(c4[3], 15, en && re);
         c32[4] = bump(c32[4], 64'hFFFF_FFFF, dr);        c4[4] = bump(c4[4], 15, dr);
      end
      p_j = jreq; p_x = bex; p_c = bcal; p_r = bres;
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("rd32", rd32, e_rd32);
      chk("rd4", rd4, e_rd4);
      chk("valid32", 32'(valid32), 32'(q.size() != 0));
      chk("valid4", 32'(valid4), 32'(q.size() != 0));
      chk("ovf32", 32'(ovf32), 32'(m_ovf));
      chk("ovf4", 32'(ovf4), 32'(m_ovf));
      if (q.size() != 0) begin
         chk("head_pc32", pc32, q[0][63:32]);
         chk("head_addr32", addr32, q[0][31:0]);
         chk("head_pc4", pc4, q[0][63:32]);
         chk("head_addr4", addr4, q[0][31:0]);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic jpulse(logic [31:0] pcv, logic [31:0] av);
      pc = pcv; jaddr = av; jreq = 1'b1;
      cycle();
      jreq = 1'b0;
      cycle();
   endtask

   initial begin
      rst = 1; en = 0; clr = 0; jreq = 0; bex = 0; bcal = 0; bres = 0; ready = 0;
      sel = 3'd0; pc = 0; jaddr = 0;
      idle(2);
      rst = 0;
      idle(1);
      chk("reset_rd", rd32, 0);
      chk("reset_valid", 32'(valid32), 0);

      // Three single-cycle jumps and one long jump.
      en = 1;
      for (int i = 0; i < 3; i++) jpulse($urandom, $urandom);
      jreq = 1;
      idle(5);
      jreq = 0;
      idle(3);
      chk("jump_cnt", rd32, 4);

      clr = 1; idle(1); clr = 0;

      // Nine jumps into an 8-deep FIFO with no consumer.
      for (int i = 0; i < 9; i++) jpulse(32'h1000 + 32'(i), 32'h2000 + 32'(i));
      sel = 3'd5; idle(2);
      chk("status_full", rd32, 32'h28);
      sel = 3'd4; idle(2);
      chk("drop_cnt", rd32, 1);

      // Full FIFO, jump edge coincident with a pop.
      ready = 1; jreq = 1; pc = 32'hAAAA_0010; jaddr = 32'hBBBB_0010;
      idle(1);
      ready = 0; jreq = 0;
      sel = 3'd5; idle(2);
      chk("level_kept", rd32, 32'h28);
      sel = 3'd4; idle(2);
      chk("no_extra_drop", rd32, 1);
      ready = 1; idle(7);
      chk("tenth_record", pc32, 32'hAAAA_0010);
      idle(2);
      ready = 0;
      clr = 1; idle(1); clr = 0;

      // Head entry holds while the consumer stalls.
      jpulse(32'h100, 32'h200);
      for (int i = 0; i < 3; i++) begin
         chk("hold_pc", pc32, 32'h100);
         chk("hold_addr", addr32, 32'h200);
         if (i < 2) idle(1);
      end
      ready = 1; idle(1); ready = 0;
      chk("valid_after_pop", 32'(valid32), 0);

      // Saturation on the 4-bit instance, then clear racing an edge.
      sel = 3'd1;
      for (int i = 0; i < 20; i++) begin
         bex = 1; idle(1); bex = 0; idle(1);
      end
      idle(1);
      chk("bex_sat4", rd4, 15);
      chk("bex32", rd32, 20);
      bex = 1; clr = 1; idle(1); clr = 0; bex = 0;
      idle(2);
      chk("bex_clr", rd32, 0);

      // Disabled counting.
      en = 0; sel = 3'd3;
      for (int i = 0; i < 5; i++) begin
         bres = 1; idle(1); bres = 0; idle(1);
      end
      idle(1);
      chk("bres_disabled", rd32, 0);
      en = 1;

      // Reset with three entries pending.
      for (int i = 0; i < 3; i++) jpulse($urandom, $urandom);
      sel = 3'd5; idle(2);
      chk("level3", rd32, 3);
      rst = 1; idle(1); rst = 0;
      chk("rst_valid", 32'(valid32), 0);
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         idle(1);
         chk("rst_read", rd32, 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         clr   = ($urandom_range(0, 79) == 0);
         en    = ($urandom_range(0, 9) != 0);
         jreq  = ($urandom_range(0, 2) == 0);
         bex   = 1'($urandom);
         bcal  = 1'($urandom);
         bres  = 1'($urandom);
         ready = ($urandom_range(0, 3) == 0);
         sel   = 3'($urandom_range(0, 7));
         pc    = $urandom;
         jaddr = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
